// File: rtl/color_sort_pkg.sv
// rtl/color_sort_pkg.sv - shared types and constants for the colour sort sequencer
package color_sort_pkg;

  typedef enum logic [2:0] {
    S_WAIT_WHITE,
    S_ARMED,
    S_CONFIRM,
    S_ACTUATE,
    S_CLEAR
  } sort_state_e;

  typedef enum logic {
    COL_RED   = 1'b0,
    COL_GREEN = 1'b1
  } color_e;

  localparam int unsigned FRAME_PIXELS   = 640 * 480;
  localparam int unsigned DEFAULT_THRESH = FRAME_PIXELS / 3;

  // Tally increment that wraps from modulus-1 back to zero.
  function automatic logic [3:0] wrap_inc(input logic [3:0] value, input int unsigned modulus);
    if (value >= 4'(modulus - 1)) begin
      return 4'd0;
    end
    return value + 4'd1;
  endfunction

endpackage

// File: rtl/ack_timeout_timer.sv
// rtl/ack_timeout_timer.sv - cycle counter that flags an overdue actuator acknowledge
module ack_timeout_timer #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int TW = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);

  logic [TW-1:0] count;

  // Count cycles spent waiting; start holds the count at zero so entry always begins fresh.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      count <= '0;
    end else if (run && (count != LAST)) begin
      count <= count + TW'(1);
    end
  end

  // Fires on the LIMIT-th waiting cycle, so the request stays up for exactly LIMIT cycles.
  assign expired = run && (count == LAST);

endmodule

// File: rtl/color_sort_sequencer.sv
// rtl/color_sort_sequencer.sv - frame-level colour debounce, actuator handshake and sort tallies
module color_sort_sequencer
  import color_sort_pkg::*;
#(
  parameter logic [31:0] THRESH         = 32'(DEFAULT_THRESH),
  parameter int unsigned CONFIRM_FRAMES = 3,
  parameter int unsigned ACK_TIMEOUT    = 1000000,
  parameter int unsigned COUNT_MOD      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_done,
  input  logic [31:0] red_pix,
  input  logic [31:0] green_pix,
  input  logic [31:0] white_pix,
  output logic        act_req,
  output logic        act_color,
  input  logic        act_ack,
  output logic [3:0]  redCount,
  output logic [3:0]  greenCount,
  output logic        redLED,
  output logic        greenLED,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CNT_W = (CONFIRM_FRAMES < 2) ? 1 : $clog2(CONFIRM_FRAMES + 1);
  localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_FRAMES - 1);

  sort_state_e      state;
  color_e           cand;
  logic [CNT_W-1:0] confirm_cnt;

  logic   is_red;
  logic   is_green;
  logic   is_white;
  color_e frame_color;

  logic timer_start;
  logic timer_run;
  logic timer_expired;

  // Per-frame classification; red wins when both colours exceed the threshold.
  always_comb begin
    is_red      = frame_done && (red_pix > THRESH);
    is_green    = frame_done && (green_pix > THRESH) && !is_red;
    is_white    = frame_done && (white_pix > THRESH);
    frame_color = is_green ? COL_GREEN : COL_RED;
  end

  // Timer is held clear outside ACTUATE so every handshake gets the full window.
  always_comb begin
    timer_start = (state != S_ACTUATE);
    timer_run   = (state == S_ACTUATE);
  end

  ack_timeout_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .run     (timer_run),
    .expired (timer_expired)
  );

  // Sequencer FSM with registered handshake, tallies and indicators.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_WAIT_WHITE;
      cand        <= COL_RED;
      confirm_cnt <= '0;
      act_req     <= 1'b0;
      act_color   <= 1'b0;
      redCount    <= 4'd0;
      greenCount  <= 4'd0;
      redLED      <= 1'b0;
      greenLED    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_WAIT_WHITE: begin
          if (is_white) begin
            state    <= S_ARMED;
            redLED   <= 1'b0;
            greenLED <= 1'b0;
          end
        end

        S_ARMED: begin
          if (is_red || is_green) begin
            cand        <= frame_color;
            confirm_cnt <= CNT_W'(1);
            busy        <= 1'b1;
            if (CONFIRM_FRAMES == 1) begin
              state     <= S_ACTUATE;
              act_req   <= 1'b1;
              act_color <= frame_color;
            end else begin
              state <= S_CONFIRM;
            end
          end
        end

        S_CONFIRM: begin
          if (is_red || is_green) begin
            if (frame_color == cand) begin
              confirm_cnt <= confirm_cnt + CNT_W'(1);
              if (confirm_cnt == CONFIRM_LAST) begin
                state     <= S_ACTUATE;
                act_req   <= 1'b1;
                act_color <= cand;
              end
            end else begin
              // A colour change restarts the debounce on the new colour.
              cand        <= frame_color;
              confirm_cnt <= CNT_W'(1);
            end
          end else if (frame_done) begin
            state       <= S_ARMED;
            confirm_cnt <= '0;
            busy        <= 1'b0;
          end
        end

        S_ACTUATE: begin
          // Ack is checked first so it wins over a simultaneous timeout.
          if (act_ack) begin
            act_req     <= 1'b0;
            confirm_cnt <= '0;
            state       <= S_CLEAR;
            if (cand == COL_GREEN) begin
              greenCount <= wrap_inc(greenCount, COUNT_MOD);
              greenLED   <= 1'b1;
              redLED     <= 1'b0;
            end else begin
              redCount <= wrap_inc(redCount, COUNT_MOD);
              redLED   <= 1'b1;
              greenLED <= 1'b0;
            end
          end else if (timer_expired) begin
            act_req     <= 1'b0;
            timeout_err <= 1'b1;
            confirm_cnt <= '0;
            busy        <= 1'b0;
            state       <= S_WAIT_WHITE;
          end
        end

        S_CLEAR: begin
          // The sorted object may still be in view; only an empty frame re-arms.
          if (is_white) begin
            state    <= S_ARMED;
            redLED   <= 1'b0;
            greenLED <= 1'b0;
            busy     <= 1'b0;
          end
        end

        default: begin
          state <= S_WAIT_WHITE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_sort_sequencer.sv
// tb/tb_color_sort_sequencer.sv - self-checking bench for color_sort_sequencer
module tb_color_sort_sequencer;
  import color_sort_pkg::*;

  localparam logic [31:0] THRESH = 32'd102400;
  localparam int CF   = 3;
  localparam int ATO  = 10;
  localparam int CMOD = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_done = 1'b0;
  logic [31:0] red_pix = '0;
  logic [31:0] green_pix = '0;
  logic [31:0] white_pix = '0;
  logic        act_ack = 1'b0;
  logic        act_req;
  logic        act_color;
  logic [3:0]  redCount;
  logic [3:0]  greenCount;
  logic        redLED;
  logic        greenLED;
  logic        busy;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass = 0;

  color_sort_sequencer #(
    .THRESH         (THRESH),
    .CONFIRM_FRAMES (CF),
    .ACK_TIMEOUT    (ATO),
    .COUNT_MOD      (CMOD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_done  (frame_done),
    .red_pix     (red_pix),
    .green_pix   (green_pix),
    .white_pix   (white_pix),
    .act_req     (act_req),
    .act_color   (act_color),
    .act_ack     (act_ack),
    .redCount    (redCount),
    .greenCount  (greenCount),
    .redLED      (redLED),
    .greenLED    (greenLED),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] outs();
    return {act_req, act_color, redCount, greenCount, redLED, greenLED, busy, timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [31:0] r, input logic [31:0] g, input logic [31:0] w);
    red_pix = r; green_pix = g; white_pix = w; frame_done = 1'b1;
    tick();
    frame_done = 1'b0; red_pix = '0; green_pix = '0; white_pix = '0;
  endtask

  task automatic pulse_ack();
    act_ack = 1'b1;
    tick();
    act_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_done = 1'b0; act_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- reference model (frame-event view) ----------------
  int m_mode;  // 0 waiting for empty frame, 1 armed/debouncing, 2 actuating, 3 waiting for object to leave
  int m_run, m_cand, m_wait, m_rc, m_gc;
  bit m_req, m_color, m_rled, m_gled, m_terr;

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_cand = 0; m_wait = 0; m_rc = 0; m_gc = 0;
    m_req = 0; m_color = 0; m_rled = 0; m_gled = 0; m_terr = 0;
  endtask

  function automatic logic [13:0] model_outs();
    bit b;
    b = (m_mode == 1 && m_run > 0) || m_mode == 2 || m_mode == 3;
    return {m_req, m_color, 4'(m_rc), 4'(m_gc), m_rled, m_gled, b, m_terr};
  endfunction

  task automatic model_step(input bit rst, input bit fd, input logic [31:0] r,
                            input logic [31:0] g, input logic [31:0] w, input bit ack);
    bit isr, isg, isw;
    int col;
    if (rst) begin
      model_reset();
      return;
    end
    isr = fd && (r > THRESH);
    isg = fd && (g > THRESH) && !isr;
    isw = fd && (w > THRESH);
    col = isg ? 1 : 0;
    case (m_mode)
      0: if (isw) begin m_mode = 1; m_run = 0; m_rled = 0; m_gled = 0; end
      1: begin
        if (isr || isg) begin
          if (m_run > 0 && col == m_cand) m_run++;
          else begin m_cand = col; m_run = 1; end
          if (m_run == CF) begin
            m_mode = 2; m_req = 1; m_color = m_cand[0]; m_wait = 0; m_run = 0;
          end
        end else if (fd) begin
          m_run = 0;
        end
      end
      2: begin
        m_wait++;
        if (ack) begin
          m_req = 0; m_mode = 3;
          if (m_cand == 1) begin m_gc = (m_gc + 1) % CMOD; m_gled = 1; m_rled = 0; end
          else begin m_rc = (m_rc + 1) % CMOD; m_rled = 1; m_gled = 0; end
        end else if (m_wait == ATO) begin
          m_req = 0; m_terr = 1; m_mode = 0;
        end
      end
      default: if (isw) begin m_mode = 1; m_rled = 0; m_gled = 0; end
    endcase
  endtask

  function automatic logic [31:0] rand_pix();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return THRESH;
      2: return THRESH + 32'd1;
      3: return 32'($urandom_range(0, 102400));
      4: return 32'd150000;
      default: return 32'($urandom);
    endcase
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (outs() !== 14'd0) $display("FAIL reset_outs: got %h expected 0", outs()); else n_pass++;
    frame(0, 0, 200000);
    n_checks++;
    if (outs() !== 14'd0) $display("FAIL armed_outs: got %h expected 0", outs()); else n_pass++;
    n_checks++;
    if (dut.state !== S_ARMED) $display("FAIL armed_state: got %0d expected %0d", dut.state, S_ARMED); else n_pass++;
  endtask

  task automatic test_red_sort();
    do_reset();
    frame(0, 0, 200000);
    frame(150000, 0, 0);
    frame(150000, 0, 0);
    n_checks++;
    if ({act_req, busy} !== 2'b01) $display("FAIL red_pre_req: req,busy=%b expected 01", {act_req, busy}); else n_pass++;
    frame(150000, 0, 0);
    n_checks++;
    if ({act_req, act_color} !== 2'b10) $display("FAIL red_req: req,color=%b expected 10", {act_req, act_color}); else n_pass++;
    tick();
    pulse_ack();
    n_checks++;
    if ({act_req, redCount, greenCount, redLED, greenLED, busy} !== {1'b0, 4'd1, 4'd0, 3'b101})
      $display("FAIL red_ack: req=%b red=%0d green=%0d leds=%b%b busy=%b expected 0 1 0 10 1",
               act_req, redCount, greenCount, redLED, greenLED, busy);
    else n_pass++;
    frame(0, 0, 200000);
    n_checks++;
    if ({redLED, busy, redCount} !== {2'b00, 4'd1}) $display("FAIL red_white_clear: led=%b busy=%b red=%0d expected 0 0 1", redLED, busy, redCount); else n_pass++;
  endtask

  task automatic test_confirm_restart();
    do_reset();
    frame(0, 0, 200000);
    frame(150000, 0, 0);
    frame(150000, 0, 0);
    frame(0, 150000, 0);
    frame(0, 150000, 0);
    n_checks++;
    if (act_req !== 1'b0) $display("FAIL restart_no_req: act_req=%b expected 0", act_req); else n_pass++;
    frame(0, 150000, 0);
    n_checks++;
    if ({act_req, act_color} !== 2'b11) $display("FAIL restart_req: req,color=%b expected 11", {act_req, act_color}); else n_pass++;
    pulse_ack();
    n_checks++;
    if ({greenCount, redCount, greenLED, redLED} !== {4'd1, 4'd0, 2'b10})
      $display("FAIL restart_counts: green=%0d red=%0d gled=%b rled=%b expected 1 0 1 0", greenCount, redCount, greenLED, redLED);
    else n_pass++;
  endtask

  task automatic test_fallback();
    do_reset();
    frame(0, 0, 200000);
    pulse_ack();
    n_checks++;
    if (outs() !== 14'd0) $display("FAIL stray_ack: outs=%h expected 0", outs()); else n_pass++;
    frame(150000, 0, 0);
    frame(150000, 0, 0);
    frame(0, 0, 0);
    frame(150000, 0, 0);
    n_checks++;
    if (act_req !== 1'b0) $display("FAIL fallback_no_req: act_req=%b expected 0", act_req); else n_pass++;
    frame(150000, 0, 0);
    n_checks++;
    if (act_req !== 1'b0) $display("FAIL fallback_early: act_req=%b expected 0", act_req); else n_pass++;
    frame(150000, 0, 0);
    n_checks++;
    if (act_req !== 1'b1) $display("FAIL fallback_req: act_req=%b expected 1", act_req); else n_pass++;
  endtask

  task automatic test_threshold();
    do_reset();
    frame(0, 0, THRESH);
    for (int i = 0; i < 3; i++) frame(150000, 0, 0);
    n_checks++;
    if ({act_req, busy} !== 2'b00) $display("FAIL white_at_thresh: req,busy=%b expected 00", {act_req, busy}); else n_pass++;
    frame(0, 0, THRESH + 32'd1);
    for (int i = 0; i < 3; i++) frame(THRESH, THRESH, 0);
    n_checks++;
    if ({act_req, busy} !== 2'b00) $display("FAIL colour_at_thresh: req,busy=%b expected 00", {act_req, busy}); else n_pass++;
    for (int i = 0; i < 3; i++) frame(THRESH + 32'd1, 32'hFFFF_FFFF, 0);
    n_checks++;
    if ({act_req, act_color} !== 2'b10) $display("FAIL red_priority: req,color=%b expected 10", {act_req, act_color}); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    frame(0, 0, 200000);
    for (int k = 1; k <= 6; k++) begin
      for (int i = 0; i < 3; i++) frame(150000, 0, 0);
      pulse_ack();
      frame(150000, 0, 0);
      n_checks++;
      if ({redCount, busy, act_req} !== {4'(k % CMOD), 2'b10})
        $display("FAIL wrap_%0d: red=%0d busy=%b req=%b expected %0d 1 0", k, redCount, busy, act_req, k % CMOD);
      else n_pass++;
      frame(0, 0, 200000);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    frame(0, 0, 200000);
    for (int i = 0; i < 3; i++) frame(0, 150000, 0);
    n = 0;
    while (act_req === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    n_checks++;
    if (n !== ATO) $display("FAIL timeout_len: act_req high %0d cycles expected %0d", n, ATO); else n_pass++;
    n_checks++;
    if ({timeout_err, greenCount, redCount, busy} !== {1'b1, 8'd0, 1'b0})
      $display("FAIL timeout_state: err=%b green=%0d red=%0d busy=%b expected 1 0 0 0", timeout_err, greenCount, redCount, busy);
    else n_pass++;
    pulse_ack();
    frame(0, 0, 200000);
    n_checks++;
    if ({timeout_err, greenCount} !== {1'b1, 4'd0}) $display("FAIL timeout_sticky: err=%b green=%0d expected 1 0", timeout_err, greenCount); else n_pass++;
    for (int i = 0; i < 3; i++) frame(150000, 0, 0);
    for (int i = 0; i < ATO - 1; i++) tick();
    pulse_ack();
    n_checks++;
    if ({act_req, redCount, redLED} !== {1'b0, 4'd1, 1'b1})
      $display("FAIL ack_beats_timeout: req=%b red=%0d led=%b expected 0 1 1", act_req, redCount, redLED);
    else n_pass++;
    frame(0, 0, 200000);
    for (int i = 0; i < 3; i++) frame(150000, 0, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({act_req, timeout_err, redCount} !== 6'd0) $display("FAIL reset_mid_act: req=%b err=%b red=%0d expected 0 0 0", act_req, timeout_err, redCount); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_random();
    bit rst, fd, ack;
    logic [31:0] r, g, w;
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      fd  = ($urandom_range(0, 1) == 1);
      ack = ($urandom_range(0, 4) == 0);
      r = rand_pix(); g = rand_pix(); w = rand_pix();
      reset = rst; frame_done = fd; act_ack = ack;
      red_pix = r; green_pix = g; white_pix = w;
      model_step(rst, fd, r, g, w, ack);
      tick();
      n_checks++;
      if (outs() !== model_outs())
        $display("FAIL random_cycle_%0d: dut=%h model=%h", i, outs(), model_outs());
      else n_pass++;
    end
    reset = 1'b0; frame_done = 1'b0; act_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_red_sort();
    test_confirm_restart();
    test_fallback();
    test_threshold();
    test_wrap();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
